// File: rtl/dlx_mem_pkg.sv
// Shared codes, FSM states and big-endian lane helpers for the MEM-stage
// load/store bridge.
package dlx_mem_pkg;

   localparam logic [1:0] SIZE_BYTE = 2'b00;
   localparam logic [1:0] SIZE_HALF = 2'b01;
   localparam logic [1:0] SIZE_WORD = 2'b10;

   typedef enum logic [2:0] {
      IDLE,
      RD_ISSUE,
      RD_WAIT_BUSY,
      RD_WAIT,
      WR_ISSUE,
      WR_WAIT_BUSY,
      WR_WAIT,
      DONE
   } state_t;

   // Big-endian: byte offset 0 lives in [31:24], so the shift is (3-off)*8.
   function automatic logic [4:0] byte_shift(input logic [1:0] off);
      return {~off, 3'b000};
   endfunction

   function automatic logic [4:0] half_shift(input logic hi_half_n);
      return hi_half_n ? 5'd0 : 5'd16;
   endfunction

   function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
      case (size)
         SIZE_BYTE: return 1'b0;
         SIZE_HALF: return off[0];
         SIZE_WORD: return off != 2'b00;
         default:   return 1'b1;
      endcase
   endfunction

endpackage

// File: rtl/dlx_byte_lane_unit.sv
// Combinational lane logic: extracts and extends a load lane from a word,
// and merges a store lane into a word for read-modify-write.
module dlx_byte_lane_unit
   import dlx_mem_pkg::*;
(
   input  logic [1:0]  size,
   input  logic [1:0]  addr_lo,
   input  logic        sign_ext,
   input  logic [31:0] rdword,
   input  logic [31:0] wdata,
   output logic [31:0] load_data,
   output logic [31:0] store_word
);

   logic [4:0]  sh;
   logic [7:0]  lane_b;
   logic [15:0] lane_h;

   always_comb begin
      sh         = '0;
      lane_b     = '0;
      lane_h     = '0;
      load_data  = rdword;
      store_word = wdata;
      case (size)
         SIZE_BYTE: begin
            sh         = byte_shift(addr_lo);
            lane_b     = 8'(rdword >> sh);
            load_data  = {{24{sign_ext & lane_b[7]}}, lane_b};
            store_word = (rdword & ~(32'h0000_00FF << sh)) | ({24'h0, wdata[7:0]} << sh);
         end
         SIZE_HALF: begin
            sh         = half_shift(addr_lo[1]);
            lane_h     = 16'(rdword >> sh);
            load_data  = {{16{sign_ext & lane_h[15]}}, lane_h};
            store_word = (rdword & ~(32'h0000_FFFF << sh)) | ({16'h0, wdata[15:0]} << sh);
         end
         default: begin
            load_data  = rdword;
            store_word = wdata;
         end
      endcase
   end

endmodule

// File: rtl/dlx_mem_access_bridge.sv
// MEM-stage front end: turns one CPU byte/half/word access into word-only
// controller transactions, with read-modify-write for sub-word stores.
module dlx_mem_access_bridge
   import dlx_mem_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  mem_req,
   input  logic                  mem_we,
   input  logic [1:0]            mem_size,
   input  logic                  mem_signed,
   input  logic [ADDR_WIDTH-1:0] mem_addr,
   input  logic [DATA_WIDTH-1:0] mem_wdata,
   output logic [DATA_WIDTH-1:0] mem_rdata,
   output logic                  mem_done,
   output logic                  mem_misaligned,
   output logic                  mem_stall,
   output logic                  data_rd_en,
   output logic                  data_wr_en,
   output logic [ADDR_WIDTH-1:0] data_addr,
   output logic [DATA_WIDTH-1:0] data_in,
   input  logic [DATA_WIDTH-1:0] data_out,
   input  logic                  data_out_valid,
   input  logic                  bus_busy
);

   state_t                state;
   logic                  we_q;
   logic                  signed_q;
   logic [1:0]            size_q;
   logic [1:0]            addr_lo_q;
   logic [DATA_WIDTH-1:0] wdata_q;
   logic [DATA_WIDTH-1:0] load_data;
   logic [DATA_WIDTH-1:0] store_word;

   assign mem_stall = mem_req & ~mem_done;

   // Lane unit works straight off data_out so the load result and merged
   // store word are both ready on the data_out_valid cycle.
   dlx_byte_lane_unit u_lane (
      .size       (size_q),
      .addr_lo    (addr_lo_q),
      .sign_ext   (signed_q),
      .rdword     (data_out),
      .wdata      (wdata_q),
      .load_data  (load_data),
      .store_word (store_word)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= IDLE;
         we_q           <= 1'b0;
         signed_q       <= 1'b0;
         size_q         <= '0;
         addr_lo_q      <= '0;
         wdata_q        <= '0;
         mem_rdata      <= '0;
         mem_done       <= 1'b0;
         mem_misaligned <= 1'b0;
         data_rd_en     <= 1'b0;
         data_wr_en     <= 1'b0;
         data_addr      <= '0;
         data_in        <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (mem_req) begin
                  we_q      <= mem_we;
                  signed_q  <= mem_signed;
                  size_q    <= mem_size;
                  addr_lo_q <= mem_addr[1:0];
                  wdata_q   <= mem_wdata;
                  data_addr <= {mem_addr[ADDR_WIDTH-1:2], 2'b00};
                  if (is_misaligned(mem_size, mem_addr[1:0])) begin
                     mem_rdata      <= '0;
                     mem_done       <= 1'b1;
                     mem_misaligned <= 1'b1;
                     state          <= DONE;
                  end else if (!mem_we || mem_size != SIZE_WORD) begin
                     state <= RD_ISSUE;
                  end else begin
                     data_in <= mem_wdata;
                     state   <= WR_ISSUE;
                  end
               end
            end
            RD_ISSUE: begin
               if (!bus_busy) begin
                  data_rd_en <= 1'b1;
                  state      <= RD_WAIT_BUSY;
               end
            end
            RD_WAIT_BUSY: begin
               data_rd_en <= 1'b0;
               if (bus_busy) state <= RD_WAIT;
            end
            RD_WAIT: begin
               if (data_out_valid) begin
                  if (we_q) begin
                     data_in <= store_word;
                     state   <= WR_ISSUE;
                  end else begin
                     mem_rdata      <= load_data;
                     mem_done       <= 1'b1;
                     mem_misaligned <= 1'b0;
                     state          <= DONE;
                  end
               end
            end
            WR_ISSUE: begin
               if (!bus_busy) begin
                  data_wr_en <= 1'b1;
                  state      <= WR_WAIT_BUSY;
               end
            end
            WR_WAIT_BUSY: begin
               data_wr_en <= 1'b0;
               if (bus_busy) state <= WR_WAIT;
            end
            WR_WAIT: begin
               if (!bus_busy) begin
                  mem_done       <= 1'b1;
                  mem_misaligned <= 1'b0;
                  state          <= DONE;
               end
            end
            DONE: begin
               mem_done       <= 1'b0;
               mem_misaligned <= 1'b0;
               state          <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dlx_mem_access_bridge.sv
// Bench for dlx_mem_access_bridge with a behavioural word-only SDRAM controller.
module tb_dlx_mem_access_bridge;

   logic        clk;
   logic        rst;
   logic        mem_req;
   logic        mem_we;
   logic [1:0]  mem_size;
   logic        mem_signed;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_done;
   logic        mem_misaligned;
   logic        mem_stall;
   logic        data_rd_en;
   logic        data_wr_en;
   logic [31:0] data_addr;
   logic [31:0] data_in;
   logic [31:0] data_out;
   logic        data_out_valid;
   logic        bus_busy;

   int unsigned checks = 0;
   int unsigned errors = 0;

   dlx_mem_access_bridge #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
      .clk            (clk),
      .rst            (rst),
      .mem_req        (mem_req),
      .mem_we         (mem_we),
      .mem_size       (mem_size),
      .mem_signed     (mem_signed),
      .mem_addr       (mem_addr),
      .mem_wdata      (mem_wdata),
      .mem_rdata      (mem_rdata),
      .mem_done       (mem_done),
      .mem_misaligned (mem_misaligned),
      .mem_stall      (mem_stall),
      .data_rd_en     (data_rd_en),
      .data_wr_en     (data_wr_en),
      .data_addr      (data_addr),
      .data_in        (data_in),
      .data_out       (data_out),
      .data_out_valid (data_out_valid),
      .bus_busy       (bus_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Controller model: busy one cycle after a request, read data 6 cycles after rd_en.
   logic        ctrl_busy;
   logic        bus_init;
   logic        rd_pend;
   logic [7:0]  rd_idx;
   int unsigned cnt;
   logic [31:0] mem_array [0:255];
   int unsigned rd_pulses  = 0;
   int unsigned wr_pulses  = 0;
   int unsigned viol       = 0;
   logic [31:0] last_addr  = '0;
   logic [31:0] last_wdata = '0;

   assign bus_busy = ctrl_busy | bus_init;

   always @(posedge clk) begin
      if (data_rd_en) begin
         rd_pulses <= rd_pulses + 1;
         last_addr <= data_addr;
      end
      if (data_wr_en) begin
         wr_pulses  <= wr_pulses + 1;
         last_addr  <= data_addr;
         last_wdata <= data_in;
      end
      if ((data_rd_en && data_wr_en) || ((data_rd_en || data_wr_en) && bus_busy))
         viol <= viol + 1;
      if (rst) begin
         ctrl_busy      <= 1'b0;
         rd_pend        <= 1'b0;
         rd_idx         <= '0;
         cnt            <= 0;
         data_out       <= '0;
         data_out_valid <= 1'b0;
      end else begin
         data_out_valid <= 1'b0;
         if (data_rd_en && !bus_busy) begin
            ctrl_busy <= 1'b1;
            rd_pend   <= 1'b1;
            rd_idx    <= data_addr[9:2];
            cnt       <= 6;
         end else if (data_wr_en && !bus_busy) begin
            mem_array[data_addr[9:2]] <= data_in;
            ctrl_busy <= 1'b1;
            rd_pend   <= 1'b0;
            cnt       <= 3;
         end else if (ctrl_busy) begin
            cnt <= cnt - 1;
            if (cnt == 1) begin
               ctrl_busy <= 1'b0;
               if (rd_pend) begin
                  data_out       <= mem_array[rd_idx];
                  data_out_valid <= 1'b1;
               end
            end
         end
      end
   end

   typedef struct {
      logic        we;
      logic [1:0]  size;
      logic        sgn;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_rdata;
      logic        exp_mis;
      logic [31:0] exp_wdata;
      int unsigned n_rd;
      int unsigned n_wr;
   } vec_t;

   typedef struct {
      logic        is_load;
      logic [31:0] rdata;
      logic        mis;
   } exp_t;

   exp_t sb[$];
   vec_t vecs[21];

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Drive one access, expected result goes to the scoreboard and is popped at mem_done.
   task automatic run_vec(input vec_t v, input int unsigned idx);
      exp_t        e;
      int unsigned lat;
      int unsigned rd0;
      int unsigned wr0;
      rd0 = rd_pulses;
      wr0 = wr_pulses;
      sb.push_back('{!v.we, v.exp_rdata, v.exp_mis});
      mem_we     = v.we;
      mem_size   = v.size;
      mem_signed = v.sgn;
      mem_addr   = v.addr;
      mem_wdata  = v.wdata;
      mem_req    = 1'b1;
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!mem_done && lat < 300);
      chk($sformatf("v%0d_done", idx), {127'h0, mem_done}, 128'h1);
      e = sb.pop_front();
      if (mem_done) begin
         chk($sformatf("v%0d_misaligned", idx), {127'h0, mem_misaligned}, {127'h0, e.mis});
         if (e.is_load && !e.mis)
            chk($sformatf("v%0d_rdata", idx), {96'h0, mem_rdata}, {96'h0, e.rdata});
         if (e.mis)
            chk($sformatf("v%0d_mis_latency_le2", idx), {127'h0, lat <= 2}, 128'h1);
      end
      mem_req = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk($sformatf("v%0d_rd_wr_pulses", idx),
          {64'h0, rd_pulses - rd0, wr_pulses - wr0}, {64'h0, v.n_rd, v.n_wr});
      if (!v.exp_mis)
         chk($sformatf("v%0d_data_addr", idx), {96'h0, last_addr}, {96'h0, v.addr[31:2], 2'b00});
      if (v.we && !v.exp_mis)
         chk($sformatf("v%0d_data_in", idx), {96'h0, last_wdata}, {96'h0, v.exp_wdata});
   endtask

   function automatic logic [127:0] all_outputs();
      return {28'h0, mem_rdata, data_in, data_addr,
              mem_done, mem_misaligned, data_rd_en, data_wr_en, mem_stall};
   endfunction

   initial begin
      int unsigned bad;
      int unsigned rd0;
      int unsigned wait_n;

      //          we    size   sgn   addr          wdata         exp_rdata     mis   exp_wdata     rd wr
      vecs[0]  = '{1'b1, 2'b10, 1'b0, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0,        1'b0, 32'hDEAD_BEEF, 0, 1};
      vecs[1]  = '{1'b0, 2'b10, 1'b0, 32'h0000_0100, 32'h0,        32'hDEAD_BEEF, 1'b0, 32'h0,        1, 0};
      vecs[2]  = '{1'b1, 2'b10, 1'b0, 32'h0000_0200, 32'h1122_3344, 32'h0,        1'b0, 32'h1122_3344, 0, 1};
      vecs[3]  = '{1'b0, 2'b00, 1'b1, 32'h0000_0203, 32'h0,        32'h0000_0044, 1'b0, 32'h0,        1, 0};
      vecs[4]  = '{1'b0, 2'b01, 1'b0, 32'h0000_0202, 32'h0,        32'h0000_3344, 1'b0, 32'h0,        1, 0};
      vecs[5]  = '{1'b0, 2'b00, 1'b0, 32'h0000_0201, 32'h0,        32'h0000_0022, 1'b0, 32'h0,        1, 0};
      vecs[6]  = '{1'b0, 2'b01, 1'b1, 32'h0000_0200, 32'h0,        32'h0000_1122, 1'b0, 32'h0,        1, 0};
      vecs[7]  = '{1'b1, 2'b00, 1'b0, 32'h0000_0201, 32'hFFFF_FFAB, 32'h0,        1'b0, 32'h11AB_3344, 1, 1};
      vecs[8]  = '{1'b0, 2'b10, 1'b0, 32'h0000_0200, 32'h0,        32'h11AB_3344, 1'b0, 32'h0,        1, 0};
      vecs[9]  = '{1'b1, 2'b10, 1'b0, 32'h0000_0200, 32'h8022_3344, 32'h0,        1'b0, 32'h8022_3344, 0, 1};
      vecs[10] = '{1'b0, 2'b00, 1'b1, 32'h0000_0200, 32'h0,        32'hFFFF_FF80, 1'b0, 32'h0,        1, 0};
      vecs[11] = '{1'b0, 2'b00, 1'b0, 32'h0000_0200, 32'h0,        32'h0000_0080, 1'b0, 32'h0,        1, 0};
      vecs[12] = '{1'b0, 2'b01, 1'b1, 32'h0000_0200, 32'h0,        32'hFFFF_8022, 1'b0, 32'h0,        1, 0};
      vecs[13] = '{1'b1, 2'b01, 1'b0, 32'h0000_0202, 32'h0000_BEEF, 32'h0,        1'b0, 32'h8022_BEEF, 1, 1};
      vecs[14] = '{1'b0, 2'b10, 1'b0, 32'h0000_0200, 32'h0,        32'h8022_BEEF, 1'b0, 32'h0,        1, 0};
      vecs[15] = '{1'b1, 2'b00, 1'b0, 32'h0000_0203, 32'h1234_565A, 32'h0,        1'b0, 32'h8022_BE5A, 1, 1};
      vecs[16] = '{1'b0, 2'b01, 1'b1, 32'h0000_0202, 32'h0,        32'hFFFF_BE5A, 1'b0, 32'h0,        1, 0};
      vecs[17] = '{1'b0, 2'b01, 1'b0, 32'h0000_0101, 32'h0,        32'h0,        1'b1, 32'h0,        0, 0};
      vecs[18] = '{1'b1, 2'b10, 1'b0, 32'h0000_0102, 32'h5555_5555, 32'h0,        1'b1, 32'h0,        0, 0};
      vecs[19] = '{1'b0, 2'b11, 1'b0, 32'h0000_0100, 32'h0,        32'h0,        1'b1, 32'h0,        0, 0};
      vecs[20] = '{1'b0, 2'b01, 1'b1, 32'h0000_0102, 32'h0,        32'hFFFF_BEEF, 1'b0, 32'h0,        1, 0};

      rst        = 1'b1;
      bus_init   = 1'b0;
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      mem_size   = 2'b00;
      mem_signed = 1'b0;
      mem_addr   = '0;
      mem_wdata  = '0;
      repeat (3) @(negedge clk);
      chk("reset_outputs", all_outputs(), 128'h0);
      rst = 1'b0;
      @(negedge clk);
      chk("post_reset_outputs", all_outputs(), 128'h0);

      for (int i = 0; i < 21; i++) run_vec(vecs[i], i);

      // Request held during controller init: no rd_en while busy, stall throughout.
      bus_init = 1'b1;
      bad = 0;
      rd0 = rd_pulses;
      sb.push_back('{1'b1, 32'hDEAD_BEEF, 1'b0});
      mem_we = 1'b0; mem_size = 2'b10; mem_signed = 1'b0; mem_addr = 32'h0000_0100;
      mem_req = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (data_rd_en || !mem_stall || mem_done) bad++;
      end
      bus_init = 1'b0;
      wait_n = 0;
      do begin
         @(negedge clk);
         wait_n++;
         if (!mem_done && !mem_stall) bad++;
      end while (!mem_done && wait_n < 300);
      chk("init_no_rd_and_stall", {96'h0, bad}, 128'h0);
      chk("init_done", {127'h0, mem_done}, 128'h1);
      begin
         exp_t e;
         e = sb.pop_front();
         chk("init_rdata", {96'h0, mem_rdata}, {96'h0, e.rdata});
      end
      mem_req = 1'b0;
      @(negedge clk);
      chk("init_rd_pulses", {96'h0, rd_pulses - rd0}, 128'h1);

      // Reset while waiting for read data abandons the access.
      mem_we = 1'b0; mem_size = 2'b10; mem_addr = 32'h0000_0200;
      mem_req = 1'b1;
      wait_n = 0;
      do begin
         @(negedge clk);
         wait_n++;
      end while (!ctrl_busy && wait_n < 100);
      chk("rstmid_reached_busy", {127'h0, ctrl_busy}, 128'h1);
      repeat (2) @(negedge clk);
      mem_req = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("rstmid_outputs", all_outputs(), 128'h0);
      repeat (10) @(negedge clk);
      chk("rstmid_no_late_done", {127'h0, mem_done}, 128'h0);
      run_vec('{1'b0, 2'b10, 1'b0, 32'h0000_0200, 32'h0, 32'h8022_BE5A, 1'b0, 32'h0, 1, 0}, 21);

      chk("protocol_violations", {96'h0, viol}, 128'h0);
      chk("scoreboard_empty", {96'h0, sb.size()}, 128'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
